// File: rtl/loop_controller.sv
// rtl/loop_controller.sv - fill/compute control FSM driving the datapath strobes.
// Fill writes N a-words then N b-words; compute runs a 10-step sequence per element.
module loop_controller #(
    parameter int N     = 100,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fill_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             category,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] index_loop,
    output logic             load_a_en,
    output logic             load_b_en,
    output logic             load_c_en,
    output logic             store_ab,
    output logic             store_c_en,
    output logic             mul_en,
    output logic             add_en,
    output logic [1:0]       mul_sel,
    output logic [1:0]       add_sel
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_LD_A,
        S_LD_B,
        S_MUL2,
        S_ADD2,
        S_ST_C1,
        S_MUL5,
        S_ADD5,
        S_LD_C,
        S_MULC,
        S_ST_C2,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic             category_q, category_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] index_loop_q, index_loop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            category_q   <= 1'b0;
            index_q      <= '0;
            index_loop_q <= '0;
        end else begin
            state_q      <= state_d;
            category_q   <= category_d;
            index_q      <= index_d;
            index_loop_q <= index_loop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        category_d   = category_q;
        index_d      = index_q;
        index_loop_d = index_loop_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (fill_en) begin
                        state_d    = S_FILL;
                        category_d = 1'b0;
                        index_d    = '0;
                    end else begin
                        state_d      = S_LD_A;
                        index_loop_d = '0;
                    end
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    if (index_q == LAST) begin
                        index_d = '0;
                        if (!category_q) begin
                            category_d = 1'b1;
                        end else begin
                            category_d   = 1'b0;
                            index_loop_d = '0;
                            state_d      = S_LD_A;
                        end
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            S_LD_A:  state_d = S_LD_B;
            S_LD_B:  state_d = S_MUL2;
            S_MUL2:  state_d = S_ADD2;
            S_ADD2:  state_d = S_ST_C1;
            S_ST_C1: state_d = S_MUL5;
            S_MUL5:  state_d = S_ADD5;
            S_ADD5:  state_d = S_LD_C;
            S_LD_C:  state_d = S_MULC;
            S_MULC:  state_d = S_ST_C2;
            S_ST_C2: begin
                if (index_loop_q < LAST) begin
                    index_loop_d = index_loop_q + IDX_W'(1);
                    state_d      = S_LD_A;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                index_loop_d = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Everything but store_ab decodes from registered state; store_ab follows the handshake.
    always_comb begin
        in_ready   = (state_q == S_FILL);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        category   = category_q;
        index      = index_q;
        index_loop = index_loop_q;
        store_ab   = in_valid & (state_q == S_FILL);
        load_a_en  = 1'b0;
        load_b_en  = 1'b0;
        load_c_en  = 1'b0;
        store_c_en = 1'b0;
        mul_en     = 1'b0;
        add_en     = 1'b0;
        mul_sel    = 2'b00;
        add_sel    = 2'b00;
        case (state_q)
            S_LD_A:  load_a_en = 1'b1;
            S_LD_B:  load_b_en = 1'b1;
            S_MUL2: begin
                mul_en  = 1'b1;
                mul_sel = 2'b01;
            end
            S_ADD2: begin
                add_en  = 1'b1;
                add_sel = 2'b01;
            end
            S_ST_C1: store_c_en = 1'b1;
            S_MUL5: begin
                mul_en  = 1'b1;
                mul_sel = 2'b10;
            end
            S_ADD5: begin
                add_en  = 1'b1;
                add_sel = 2'b10;
            end
            S_LD_C:  load_c_en = 1'b1;
            S_MULC: begin
                mul_en  = 1'b1;
                mul_sel = 2'b11;
            end
            S_ST_C2: begin
                store_c_en = 1'b1;
                mul_sel    = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/loop_controller.md
Name: loop_controller

Overview:
- Control FSM sitting directly upstream of the compute datapath. It drives every datapath control strobe.
- Fill phase: accepts N a-words and then N b-words over a valid/ready stream and issues the store strobes that write them to SRAM.
- Compute phase: for each i, sequences c[i] = a[i] + 2*b[i], then c[i] = c[i] * (a[i] + 5*b[i]).
- Signals busy throughout and pulses done on completion.

Parameters:
- N, 100, number of elements per array; legal range 1..100.
- IDX_W, 10, width of the index and index_loop outputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- fill_en  in  1  sampled with start. 1: fill phase, then compute. 0: compute only, reusing SRAM contents.
- in_valid  in  1  upstream word valid. Data travels on the datapath's a_data/b_data directly.
- in_ready  out  1  controller can accept a word this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when compute completes.
- category  out  1  0 = a array, 1 = b array.
- index  out  IDX_W  fill write index.
- index_loop  out  IDX_W  compute element index.
- load_a_en, load_b_en, load_c_en  out  1 each  datapath load strobes.
- store_ab  out  1  fill write strobe.
- store_c_en  out  1  c write strobe.
- mul_en, add_en  out  1 each  datapath operation strobes.
- mul_sel  out  2  01 = b*2, 10 = b*5, 11 = c*(a+5b).
- add_sel  out  2  01 = a+2b, 10 = a+5b.

Behaviour:
- Reset (synchronous, clk edge with rst=1): state IDLE, counters 0. All outputs 0: category, index, index_loop, every strobe, mul_sel, add_sel, in_ready, busy, done. rst has priority over every other input.
- Output decoding: all outputs are decoded from registered state and counters. The one exception is store_ab = in_valid & in_ready, which is combinational.
- Strobe exclusivity: at most one of load_a_en, load_b_en, load_c_en, store_ab, store_c_en, mul_en, add_en is high in any cycle.
- IDLE:
  - start=1 & fill_en=1 -> FILL, with category=0 and index=0.
  - start=1 & fill_en=0 -> LD_A, with index_loop=0.
- FILL:
  - in_ready=1.
  - On each cycle with in_valid=1: store_ab=1 and index increments.
  - When index=N-1 and category=0 and a word is accepted: index wraps to 0 and category becomes 1.
  - When index=N-1 and category=1 and a word is accepted: -> LD_A, index_loop=0, category=0, index=0.
  - in_valid=0 stalls with no state change.
- Compute sequence: exactly one state per cycle, 10 cycles per element, in this order.
  - LD_A: load_a_en=1.
  - LD_B: load_b_en=1.
  - MUL2: mul_en=1, mul_sel=01.
  - ADD2: add_en=1, add_sel=01.
  - ST_C1: store_c_en=1, mul_sel=00.
  - MUL5: mul_en=1, mul_sel=10.
  - ADD5: add_en=1, add_sel=10.
  - LD_C: load_c_en=1.
  - MULC: mul_en=1, mul_sel=11.
  - ST_C2: store_c_en=1, mul_sel=11.
- After ST_C2:
  - index_loop < N-1: increment index_loop, -> LD_A.
  - index_loop = N-1: -> DONE, with index_loop held at N-1.
- DONE: done=1 and busy=1 for one cycle, then -> IDLE with index_loop cleared to 0.
- Timing, compute only: start at cycle 0 gives first load_a_en at cycle 1, done at cycle 10*N+1, busy low at cycle 10*N+2.
- start while busy is ignored. in_valid outside FILL is ignored: in_ready=0, store_ab=0.
- Reset mid-FILL or mid-compute returns to IDLE next cycle with all outputs 0. Partial SRAM contents are not tracked.
- Counters never exceed N-1. index and index_loop use zero-extended IDX_W arithmetic.

Test Plan:
- N=4, rst held 3 cycles -> every output 0, busy=0 on each of those cycles. Release, no start -> outputs stay 0.
- N=4, start with fill_en=1, in_valid held high -> 8 consecutive store_ab pulses:
  - indices 0,1,2,3 with category=0, then 0,1,2,3 with category=1;
  - then load_a_en with index_loop=0 on the next cycle.
- N=4, fill with in_valid toggling 1,0,1,0 -> store_ab only on the valid cycles, index holds across gaps, exactly 8 writes total.
- N=4, start with fill_en=0 -> 40 compute cycles:
  - strobe pattern repeats with period 10, index_loop 0..3;
  - store_c_en on cycles 5 and 10 of each period, mul_sel 00 then 11;
  - done exactly at cycle 41, busy low at 42.
- N=4, start re-pulsed mid-compute -> ignored, done timing unchanged. Assert rst at index_loop=2 -> IDLE next cycle, all strobes 0, then a fresh start restarts at index_loop=0.
- N=1, fill_en=0 -> single 10-cycle sequence, done at cycle 11. Assertion across all tests: never more than one strobe high in a cycle.
